barrel_shifter_pipe: RTL and testbench
======================================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have parameter AMT_W, default 8, shift-amount width.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, operation offered.
REQ-007 SHALL have port in_ready, output, 1, operation accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, WIDTH, operand.
REQ-009 SHALL have port in_type, input, 2, shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 SHALL have port in_amt, input, AMT_W, shift amount.
REQ-011 SHALL have port in_imm, input, 1, immediate-encoding mode (1) versus register mode (0).
REQ-012 SHALL have port in_carry, input, 1, current C flag.
REQ-013 SHALL have port in_tag, input, TAG_W, sideband tag, returned unchanged.
REQ-014 SHALL have port out_valid, output, 1, result present.
REQ-015 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-016 SHALL have port out_data, output, WIDTH, shifted result.
REQ-017 SHALL have port out_carry, output, 1, shifter carry-out.
REQ-018 SHALL have port out_tag, output, TAG_W, tag of the result.

Function
REQ-019 SHALL be a two-stage pipeline.
- S1 registers the decoded operation: effective type, effective amount, RRX flag, operand, carry and tag.
- S2 registers the result.
- Latency from acceptance to out_valid is 2 cycles; throughput is 1 operation per cycle.
REQ-020 SHALL load S2 when S2 is empty or out_ready=1, and load S1 when S1 is empty or S1 moves to S2.
- in_ready = !s1_valid || s2_load.
- in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 SHALL hold out_data, out_carry and out_tag stable while out_valid && !out_ready.
REQ-022 SHALL, in immediate mode (in_imm=1), decode amounts as follows:
- LSR #0 and ASR #0 mean amount WIDTH.
- ROR #0 means RRX.
- LSL #0 means no shift.
REQ-023 SHALL, in register mode (in_imm=0), treat amount 0 as no shift for every type: out_data=in_data, out_carry=in_carry.
REQ-024 SHALL compute LSL by n as follows:
- 1≤n<WIDTH: data<<n, carry=data[WIDTH-n].
- n=WIDTH: 0, carry=data[0].
- n>WIDTH: 0, carry 0.
REQ-025 SHALL compute LSR by n as follows:
- 1≤n<WIDTH: data>>n, carry=data[n-1].
- n=WIDTH: 0, carry=data[WIDTH-1].
- n>WIDTH: 0, carry 0.
REQ-026 SHALL compute ASR by n as follows:
- 1≤n<WIDTH: arithmetic shift, carry=data[n-1].
- n≥WIDTH: all bits and carry equal data[WIDTH-1].
REQ-027 SHALL compute ROR by n≥1 as follows:
- Result is right-rotate by n mod WIDTH.
- If n mod WIDTH = 0: data unchanged, carry=data[WIDTH-1].
- Otherwise: carry=result[WIDTH-1].
REQ-028 SHALL compute RRX as out_data={in_carry, data[WIDTH-1:1]}, out_carry=data[0].
REQ-029 SHALL evaluate amounts over the full AMT_W range (0..2^AMT_W-1) with no truncation before the comparisons in REQ-024..027.

Reset
REQ-030 SHALL, while rst=1 at a clk edge, clear S1 and S2 valid.
- Resulting outputs: out_valid=0, in_ready=1.
- out_data=0, out_carry=0, out_tag=0.
REQ-031 SHALL discard in-flight operations when reset is asserted mid-operation; nothing accepted before the reset edge appears afterwards.
REQ-032 SHALL ignore in_valid during the reset cycle; no operation is accepted then.

Structure
REQ-033 SHALL take the shift-type encodings (LSL/LSR/ASR/ROR) and the decoded-operation record type from the shared package shift_pkg.
REQ-034 SHALL implement the S2 datapath as the combinational sub-module shift_core (WIDTH-parameterised, producing data and carry), instantiated once.

Verification
REQ-035 Bench SHALL cover: imm LSR #0 on 0x80000001 -> out_data 0x00000000, out_carry 1.
REQ-036 Bench SHALL cover: reg ROR amt 36 on 0x0000000F -> out_data 0xF0000000, out_carry 1; reg ROR amt 32 on 0x80000000 -> data unchanged, carry 1.
REQ-037 Bench SHALL cover: imm ROR #0 (RRX) on 0x00000003 with in_carry=1 -> 0x80000001, out_carry 1.
REQ-038 Bench SHALL cover: reg LSL amt 0 with in_carry=1 -> data unchanged, carry 1; LSL 33 -> 0, carry 0; ASR 200 on 0x80000000 -> 0xFFFFFFFF, carry 1.
REQ-039 Bench SHALL cover: back-to-back stream of 8 tagged operations with out_ready held 0 for 3 cycles mid-stream.
- in_ready=0 while both stages are full.
- No loss or duplication; tags in order.
- 1 operation/cycle once out_ready=1.
REQ-040 Bench SHALL cover: rst asserted with both stages full -> next cycle out_valid=0, in_ready=1, and no stale result is emitted.

Source files
------------

// File: rtl/shift_pkg.sv
// Shift-type encodings and the decoded-operation record shared by the barrel shifter.
package shift_pkg;

    // Width of the decoded amount field; it holds 0..WIDTH+1 for WIDTH up to 64.
    localparam int unsigned EFF_AMT_W = 8;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // Decoded operation as held in S1.
    // amt == 0 means no shift (data and carry pass through).
    // For LSL/LSR/ASR, amt is saturated at WIDTH+1.
    // For ROR, amt is 1..WIDTH, and WIDTH stands for a full rotation.
    // rrx overrides kind/amt with a one-bit rotate through carry.
    typedef struct packed {
        shift_type_e          kind;
        logic                 rrx;
        logic [EFF_AMT_W-1:0] amt;
    } shift_op_t;

endpackage : shift_pkg

// File: rtl/shift_core.sv
// Combinational shifter datapath.
// It works on an already decoded operation, so each shift type reduces to a plain
// shift of an operand widened by one bit. That extra bit captures the last bit
// shifted out.
module shift_core
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  shift_op_t        op,
    input  logic [WIDTH-1:0] data,
    input  logic             carry_in,
    output logic [WIDTH-1:0] res_data_c,
    output logic             res_carry_c
);

    localparam int unsigned LOG_W = $clog2(WIDTH);

    logic [WIDTH:0]        lsl_t;
    logic [WIDTH:0]        lsr_t;
    logic signed [WIDTH:0] asr_t;
    logic [LOG_W-1:0]      ror_k;
    logic [WIDTH-1:0]      ror_t;

    // Evaluate all shift forms, then select by decoded type.
    always_comb begin
        lsl_t = {1'b0, data} << op.amt;
        lsr_t = {data, 1'b0} >> op.amt;
        asr_t = $signed({data, 1'b0}) >>> op.amt;
        ror_k = op.amt[LOG_W-1:0];
        ror_t = WIDTH'({data, data} >> ror_k);

        res_data_c  = data;
        res_carry_c = carry_in;

        if (op.rrx) begin
            res_data_c  = {carry_in, data[WIDTH-1:1]};
            res_carry_c = data[0];
        end else if (op.amt != '0) begin
            case (op.kind)
                SH_LSL: begin
                    res_data_c  = lsl_t[WIDTH-1:0];
                    res_carry_c = lsl_t[WIDTH];
                end
                SH_LSR: begin
                    res_data_c  = lsr_t[WIDTH:1];
                    res_carry_c = lsr_t[0];
                end
                SH_ASR: begin
                    res_data_c  = asr_t[WIDTH:1];
                    res_carry_c = asr_t[0];
                end
                default: begin
                    res_data_c  = ror_t;
                    res_carry_c = ror_t[WIDTH-1];
                end
            endcase
        end
    end

endmodule : shift_core

// File: rtl/barrel_shifter_pipe.sv
// Two-stage barrel shifter with a valid/ready interface.
// S1 holds the decoded operation and S2 holds the result.
module barrel_shifter_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_type,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_imm,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LOG_W   = $clog2(WIDTH);
    // Widened amount: comparisons against WIDTH see every bit of in_amt.
    localparam int unsigned AMT_X_W = AMT_W + 8;

    shift_type_e        dec_kind;
    shift_op_t          dec_op;
    logic [AMT_X_W-1:0] amt_x;
    logic               amt_zero;
    logic               amt_over;
    logic [LOG_W-1:0]   ror_mod;

    logic               s1_load;
    logic               s2_load;

    logic               s1_valid_q, s1_valid_d;
    shift_op_t          s1_op_q,    s1_op_d;
    logic [WIDTH-1:0]   s1_data_q,  s1_data_d;
    logic               s1_carry_q, s1_carry_d;
    logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;

    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   s2_data_q,  s2_data_d;
    logic               s2_carry_q, s2_carry_d;
    logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;

    logic [WIDTH-1:0]   core_data_c;
    logic               core_carry_c;

    // Decode the offered operation into a type and an effective amount in 0..WIDTH+1.
    always_comb begin
        dec_kind   = shift_type_e'(in_type);
        amt_x      = AMT_X_W'(in_amt);
        amt_zero   = (amt_x == '0);
        amt_over   = (amt_x > AMT_X_W'(WIDTH));
        ror_mod    = amt_x[LOG_W-1:0];
        dec_op     = '0;
        dec_op.kind = dec_kind;

        if (amt_zero) begin
            // #0 has special meanings only in immediate encoding.
            if (in_imm) begin
                case (dec_kind)
                    SH_LSR, SH_ASR: dec_op.amt = EFF_AMT_W'(WIDTH);
                    SH_ROR:         dec_op.rrx = 1'b1;
                    default:        dec_op.amt = '0;
                endcase
            end
        end else if (dec_kind == SH_ROR) begin
            // A multiple of WIDTH is a full rotation; it is kept distinct from "no shift".
            dec_op.amt = (ror_mod == '0) ? EFF_AMT_W'(WIDTH) : EFF_AMT_W'(ror_mod);
        end else if (amt_over) begin
            dec_op.amt = EFF_AMT_W'(WIDTH + 1);
        end else begin
            dec_op.amt = EFF_AMT_W'(amt_x);
        end
    end

    // Result datapath between S1 and S2.
    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op          (s1_op_q),
        .data        (s1_data_q),
        .carry_in    (s1_carry_q),
        .res_data_c  (core_data_c),
        .res_carry_c (core_carry_c)
    );

    // Pipeline advance: each stage loads when it is empty or its contents move on.
    always_comb begin
        s2_load = !s2_valid_q || out_ready;
        s1_load = !s1_valid_q || s2_load;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_data_d  = s1_data_q;
        s1_carry_d = s1_carry_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_carry_d = s2_carry_q;
        s2_tag_d   = s2_tag_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d    = dec_op;
                s1_data_d  = in_data;
                s1_carry_d = in_carry;
                s1_tag_d   = in_tag;
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = core_data_c;
                s2_carry_d = core_carry_c;
                s2_tag_d   = s1_tag_q;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_data_q  <= '0;
            s1_carry_q <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_carry_q <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_data_q  <= s1_data_d;
            s1_carry_q <= s1_carry_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_carry_q <= s2_carry_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_carry = s2_carry_q;
    assign out_tag   = s2_tag_q;

endmodule : barrel_shifter_pipe

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe.
// The driver pushes expected results on acceptance, and the monitor pops them on
// each output handshake.
module tb_barrel_shifter_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AMT_W = 8;
    localparam int unsigned TAG_W = 4;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  typ;
        logic [7:0]  amt;
        logic        imm;
        logic        carry;
        logic [3:0]  tag;
        bit          use_exp;
        logic [31:0] exp_data;
        logic        exp_carry;
    } stim_t;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic [3:0]  tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_type;
    logic [AMT_W-1:0] in_amt;
    logic             in_imm;
    logic             in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    stim_t      stim_q[$];
    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_out    = 0;
    logic [3:0] tag_ctr  = 4'd0;

    barrel_shifter_pipe #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_type   (in_type),
        .in_amt    (in_amt),
        .in_imm    (in_imm),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Reference model for WIDTH=32, written directly from the shift rules.
    function automatic exp_t ref_model(input stim_t s);
        exp_t        e;
        int unsigned n;
        int unsigned k;
        logic [31:0] d;
        d     = s.data;
        n     = 32'(s.amt);
        e.tag = s.tag;
        if (n == 0 && (!s.imm || s.typ == 2'b00)) begin
            e.data  = d;
            e.carry = s.carry;
            return e;
        end
        if (n == 0 && s.typ == 2'b11) begin
            e.data  = {s.carry, d[31:1]};
            e.carry = d[0];
            return e;
        end
        if (n == 0) n = 32;
        case (s.typ)
            2'b00: begin
                if (n < 32)       begin e.data = d << n; e.carry = d[32-n]; end
                else if (n == 32) begin e.data = '0;     e.carry = d[0];    end
                else              begin e.data = '0;     e.carry = 1'b0;    end
            end
            2'b01: begin
                if (n < 32)       begin e.data = d >> n; e.carry = d[n-1];  end
                else if (n == 32) begin e.data = '0;     e.carry = d[31];   end
                else              begin e.data = '0;     e.carry = 1'b0;    end
            end
            2'b10: begin
                if (n < 32) begin e.data = 32'($signed(d) >>> n); e.carry = d[n-1]; end
                else        begin e.data = {32{d[31]}};           e.carry = d[31];  end
            end
            default: begin
                k       = n % 32;
                e.data  = (d >> k) | (d << (32 - k));
                e.carry = (k == 0) ? d[31] : e.data[31];
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dir(input logic [31:0] d, input logic [1:0] t, input logic [7:0] a,
                            input logic imm, input logic c, input logic [31:0] ed, input logic ec);
        stim_t s;
        s = '{data: d, typ: t, amt: a, imm: imm, carry: c, tag: tag_ctr,
              use_exp: 1'b1, exp_data: ed, exp_carry: ec};
        stim_q.push_back(s);
        tag_ctr++;
    endtask

    task automatic push_rand();
        stim_t s;
        case ($urandom_range(0, 3))
            0:       s.data = 32'h8000_0000 | $urandom;
            1:       s.data = 32'($urandom_range(0, 15));
            default: s.data = $urandom;
        endcase
        s.typ = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       s.amt = 8'($urandom_range(0, 2));
            1:       s.amt = 8'($urandom_range(30, 34));
            default: s.amt = 8'($urandom_range(0, 255));
        endcase
        s.imm       = 1'($urandom_range(0, 1));
        s.carry     = 1'($urandom_range(0, 1));
        s.tag       = tag_ctr;
        s.use_exp   = 1'b0;
        s.exp_data  = '0;
        s.exp_carry = 1'b0;
        stim_q.push_back(s);
        tag_ctr++;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && cyc < 400) begin
            tick();
            cyc++;
        end
        check(name, 64'(stim_q.size() + exp_q.size()), 64'd0);
    endtask

    // Driver: offers the queue head, and offers junk while reset is high.
    initial begin : driver
        stim_t s;
        exp_t  e;
        bit    drv_real;
        in_valid = 1'b0;
        in_data  = '0;
        in_type  = '0;
        in_amt   = '0;
        in_imm   = 1'b0;
        in_carry = 1'b0;
        in_tag   = '0;
        forever begin
            @(posedge clk);
            #2;
            drv_real = 1'b0;
            if (rst) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                in_type  = 2'($urandom_range(0, 3));
                in_amt   = 8'($urandom_range(0, 255));
                in_imm   = 1'($urandom_range(0, 1));
                in_carry = 1'($urandom_range(0, 1));
                in_tag   = 4'($urandom_range(0, 15));
            end else if (stim_q.size() != 0) begin
                s        = stim_q[0];
                in_valid = 1'b1;
                in_data  = s.data;
                in_type  = s.typ;
                in_amt   = s.amt;
                in_imm   = s.imm;
                in_carry = s.carry;
                in_tag   = s.tag;
                drv_real = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (rst) begin
                stim_q.delete();
            end else if (drv_real && in_ready) begin
                if (s.use_exp) e = '{data: s.exp_data, carry: s.exp_carry, tag: s.tag};
                else           e = ref_model(s);
                exp_q.push_back(e);
                void'(stim_q.pop_front());
            end
        end
    end

    // Monitor: compares every output handshake against the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got tag %0d data 0x%08h, required no output",
                             out_tag, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data",  64'(out_data),  64'(e.data));
                    check("out_carry", 64'(out_carry), 64'(e.carry));
                    check("out_tag",   64'(out_tag),   64'(e.tag));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int n0;
        rst       = 1'b1;
        out_ready = 1'b1;

        // Reset state, with in_valid asserted by the driver throughout.
        tick();
        tick();
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_data",  64'(out_data),  64'd0);
        check("reset_out_carry", 64'(out_carry), 64'd0);
        check("reset_out_tag",   64'(out_tag),   64'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("no_accept_in_reset", 64'(n_out), 64'd0);

        // Directed corner cases.
        push_dir(32'h8000_0001, 2'b01, 8'd0,   1'b1, 1'b0, 32'h0000_0000, 1'b1);
        push_dir(32'h0000_000F, 2'b11, 8'd36,  1'b0, 1'b0, 32'hF000_0000, 1'b1);
        push_dir(32'h8000_0000, 2'b11, 8'd32,  1'b0, 1'b0, 32'h8000_0000, 1'b1);
        push_dir(32'h0000_0003, 2'b11, 8'd0,   1'b1, 1'b1, 32'h8000_0001, 1'b1);
        push_dir(32'h1234_5678, 2'b00, 8'd0,   1'b0, 1'b1, 32'h1234_5678, 1'b1);
        push_dir(32'hFFFF_FFFF, 2'b00, 8'd33,  1'b0, 1'b1, 32'h0000_0000, 1'b0);
        push_dir(32'h8000_0000, 2'b10, 8'd200, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        push_dir(32'h8000_0000, 2'b10, 8'd0,   1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        push_dir(32'h0000_0001, 2'b00, 8'd32,  1'b0, 1'b0, 32'h0000_0000, 1'b1);
        push_dir(32'h0000_0003, 2'b01, 8'd1,   1'b0, 1'b0, 32'h0000_0001, 1'b1);
        push_dir(32'hA5A5_0000, 2'b00, 8'd0,   1'b1, 1'b0, 32'hA5A5_0000, 1'b0);
        wait_drain("directed_drain");

        // Back-to-back stream with a 3-cycle output stall.
        for (int i = 0; i < 8; i++) push_rand();
        repeat (4) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready",  64'(in_ready),  64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            if (exp_q.size() != 0) begin
                check("stall_out_tag",  64'(out_tag),  64'(exp_q[0].tag));
                check("stall_out_data", 64'(out_data), 64'(exp_q[0].data));
            end else begin
                check("stall_pending", 64'(exp_q.size()), 64'd1);
            end
        end
        tick();
        out_ready = 1'b1;
        n0 = n_out;
        repeat (4) tick();
        check("throughput_4_cycles", 64'(n_out - n0), 64'd4);
        wait_drain("stream_drain");

        // Random operations with random output back-pressure.
        for (int i = 0; i < 40; i++) push_rand();
        for (int i = 0; i < 80; i++) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        wait_drain("random_drain");

        // Reset while both stages are full.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_rand();
        cyc = 0;
        @(negedge clk);
        while (in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("full_in_ready",  64'(in_ready),  64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_out_data",  64'(out_data),  64'd0);
        check("midrst_out_tag",   64'(out_tag),   64'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        n0        = n_out;
        repeat (8) tick();
        check("no_stale_after_reset", 64'(n_out - n0), 64'd0);

        // Pipeline still works after the mid-run reset.
        push_dir(32'h0000_00F0, 2'b01, 8'd4, 1'b0, 1'b0, 32'h0000_000F, 1'b0);
        for (int i = 0; i < 6; i++) push_rand();
        wait_drain("post_reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_barrel_shifter_pipe
